// File: rtl/du_uart_word_tx.sv
// du_uart_word_tx: serialises a 32-bit word as NB_WORD/NB_BYTE 8N1 UART frames, least-significant byte first
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_word         word to transmit, sampled only on accept
//   i_valid        word-valid request
//   o_ready        a word can be accepted this cycle
//   o_uart_tx_data serial line, idles high
//   o_busy         a word is being transmitted
//   o_done         1-cycle pulse when the last stop bit of the word completes
module du_uart_word_tx #(
   parameter int NB_WORD      = 32,
   parameter int NB_BYTE      = 8,
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_WORD-1:0] i_word,
   input  logic               i_valid,
   output logic               o_ready,
   output logic               o_uart_tx_data,
   output logic               o_busy,
   output logic               o_done
);
   localparam int N_BYTES = NB_WORD / NB_BYTE;
   localparam int NB_BAUD = $clog2(CLKS_PER_BIT);
   localparam int NB_BIT  = NB_BYTE > 1 ? $clog2(NB_BYTE) : 1;
   localparam int NB_BCNT = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t             state_q;
   logic [NB_WORD-1:0] shift_q;
   logic [NB_BAUD-1:0] baud_q;
   logic [NB_BIT-1:0]  bit_q;
   logic [NB_BCNT-1:0] byte_q;
   logic               ready_q, tx_q, busy_q, done_q;
   logic               baud_end;
   assign baud_end       = baud_q == NB_BAUD'(CLKS_PER_BIT - 1);
   assign o_ready        = ready_q;
   assign o_uart_tx_data = tx_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         ready_q <= 1'b1;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         baud_q <= (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
         case (state_q)
            IDLE: if (i_valid && ready_q) begin
               shift_q <= i_word;
               state_q <= START;
               tx_q    <= 1'b0;
               busy_q  <= 1'b1;
               ready_q <= 1'b0;
            end
            START: if (baud_end) begin
               state_q <= DATA;
               tx_q    <= shift_q[0];
               bit_q   <= '0;
            end
            // The register shifts on every data-bit boundary, so after the last
            // bit of a byte the next byte's LSB already sits in shift_q[0].
            DATA: if (baud_end) begin
               shift_q <= shift_q >> 1;
               if (bit_q == NB_BIT'(NB_BYTE - 1)) begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
               end else begin
                  bit_q <= bit_q + 1'b1;
                  tx_q  <= shift_q[1];
               end
            end
            STOP: if (baud_end) begin
               if (byte_q == NB_BCNT'(N_BYTES - 1)) begin
                  state_q <= IDLE;
                  byte_q  <= '0;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  byte_q  <= byte_q + 1'b1;
                  state_q <= START;
                  tx_q    <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_du_uart_word_tx.sv
// tb_du_uart_word_tx: directed self-checking bench for du_uart_word_tx with CLKS_PER_BIT=4
module tb_du_uart_word_tx;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] word;
   logic        valid;
   logic        ready, tx, busy, done;
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;

   du_uart_word_tx #(.NB_WORD(32), .NB_BYTE(8), .CLKS_PER_BIT(4)) dut (
      .i_clock(clk), .i_reset(rst_n), .i_word(word), .i_valid(valid),
      .o_ready(ready), .o_uart_tx_data(tx), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered on the first start-bit cycle; samples every bit mid-way and
   // returns on the o_done cycle (160 cycles later).
   task automatic rx_word(input string tag, input logic [31:0] exp);
      logic [7:0] b;
      int d0;
      d0 = done_cnt;
      for (int k = 0; k < 4; k++) begin
         repeat (2) @(negedge clk);
         check({tag, " start"}, 32'(tx), 32'd0);
         check({tag, " ready_low"}, 32'(ready), 32'd0);
         check({tag, " busy"}, 32'(busy), 32'd1);
         for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = tx;
         end
         check({tag, " byte"}, 32'(b), 32'(exp[8*k +: 8]));
         repeat (4) @(negedge clk);
         check({tag, " stop"}, 32'(tx), 32'd1);
         repeat (2) @(negedge clk);
      end
      check({tag, " done_at_160"}, 32'(done), 32'd1);
      check({tag, " done_count"}, 32'(done_cnt - d0), 32'd0);
      check({tag, " ready_end"}, 32'(ready), 32'd1);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check({tag, " start_timeout"}, 32'(tx), 32'd0);
   endtask

   task automatic send(input logic [31:0] w);
      word  = w;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   initial begin
      int d0;
      rst_n = 1'b0;
      word  = '0;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // 1: idle after reset
      d0 = done_cnt;
      repeat (100) @(negedge clk);
      check("idle line", 32'(tx), 32'd1);
      check("idle ready", 32'(ready), 32'd1);
      check("idle busy", 32'(busy), 32'd0);
      check("idle no_done", 32'(done_cnt - d0), 32'd0);
      // 2: basic word, exact timing
      send(32'hAABBCCDD);
      check("t2 first_start", 32'(tx), 32'd0);
      d0 = done_cnt;
      rx_word("t2", 32'hAABBCCDD);
      @(negedge clk);
      check("t2 done_pulse_1", 32'(done), 32'd0);
      check("t2 done_once", 32'(done_cnt - d0), 32'd1);
      repeat (5) @(negedge clk);
      // 3: back-to-back with valid held through o_done
      word  = 32'h00000000;
      valid = 1'b1;
      @(negedge clk);
      word = 32'hFFFFFFFF;
      check("t3 first_start", 32'(tx), 32'd0);
      rx_word("t3a", 32'h00000000);
      @(negedge clk);
      valid = 1'b0;
      check("t3 no_gap", 32'(tx), 32'd0);
      rx_word("t3b", 32'hFFFFFFFF);
      repeat (5) @(negedge clk);
      // 4: request while busy is ignored
      send(32'h11223344);
      wait_start("t4");
      fork
         rx_word("t4", 32'h11223344);
         begin
            repeat (50) @(negedge clk);
            word  = 32'h12345678;
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      check("t4 no_second line", 32'(tx), 32'd1);
      check("t4 no_second busy", 32'(busy), 32'd0);
      // 5: asynchronous reset during byte 2, data bit 3
      send(32'h00000000);
      repeat (98) @(negedge clk);
      check("t5 mid_frame", 32'(tx), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t5 rst line", 32'(tx), 32'd1);
      check("t5 rst ready", 32'(ready), 32'd1);
      check("t5 rst busy", 32'(busy), 32'd0);
      check("t5 rst done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("t5 post line", 32'(tx), 32'd1);
      send(32'h000000A5);
      wait_start("t5");
      rx_word("t5", 32'h000000A5);
      repeat (5) @(negedge clk);
      // 6: i_word scrambled every cycle after accept
      send(32'hDEADBEEF);
      wait_start("t6");
      fork
         rx_word("t6", 32'hDEADBEEF);
         repeat (155) begin
            word = $urandom;
            @(negedge clk);
         end
      join
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
